gate_accum: RTL

Parametrised multi-operand logic-gate unit, the sequential successor of the two-input combinational gates. It applies a selectable bitwise operation across a frame of `n_ops` WIDTH-bit operands. Operands arrive one per valid/ready handshake, and the result is presented on a registered valid/ready output. It serves as the reusable gate core for the lab's datapath exercises and replaces the per-gate modules.

---
 rtl/gate_accum.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gate_accum.sv
// gate_accum: applies one bitwise gate (AND/OR/XOR and their complements)
// across a frame of n_ops operands received over a valid/ready input.
// The result is presented on a registered valid/ready output.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start, op, n_ops     frame request; sampled only in IDLE
//   in_valid, in_data    operand stream; in_ready is high in ACC
//   out_valid, out_ready result handshake
//   out_data, out_count  frame result and operand count, held until taken
//   busy                 high while a frame is in ACC or DONE
//   err                  one-cycle pulse on a start with an illegal n_ops
module gate_accum #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_MAX = 8,
    parameter int unsigned CNT_W = $clog2(N_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] n_ops,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    // Scratch values for the operand being accepted this cycle
    logic [WIDTH-1:0] acc_new;
    logic [CNT_W-1:0] cnt_inc;
    logic             invert;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            n_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        err_d       = 1'b0;
        acc_new     = acc_q;
        cnt_inc     = cnt_q + CNT_W'(1);
        invert      = (op_q == 3'b011) || (op_q == 3'b100) || (op_q == 3'b101);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((n_ops == '0) || (n_ops > CNT_W'(N_MAX))) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = op;
                        n_d     = n_ops;
                        cnt_d   = '0;
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    // First operand seeds the accumulator; later ones fold in
                    if (cnt_q == '0) begin
                        acc_new = in_data;
                    end else begin
                        case (op_q)
                            3'b001, 3'b100: acc_new = acc_q | in_data;
                            3'b010, 3'b101: acc_new = acc_q ^ in_data;
                            default:        acc_new = acc_q & in_data;
                        endcase
                    end
                    acc_d = acc_new;
                    cnt_d = cnt_inc;
                    if (cnt_inc == n_q) begin
                        out_data_d  = invert ? ~acc_new : acc_new;
                        out_count_d = n_q;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered copies of the upcoming state
        in_ready_d  = (state_d == S_ACC);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
